// File: rtl/measurement_byte_serializer_if.sv
// Handshake bundle between a round producer / byte consumer (master) and
// the measurement byte serializer (slave).
interface measurement_byte_serializer_if #(
    parameter int PU_COUNT = 4
);
    logic [PU_COUNT-1:0] round_measurements;
    logic                round_valid;
    logic                round_ready;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic                block_done;

    // Producer of rounds and consumer of bytes.
    modport master (
        output round_measurements,
        output round_valid,
        input  round_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  block_done
    );

    // The serializer itself.
    modport slave (
        input  round_measurements,
        input  round_valid,
        output round_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output block_done
    );
endinterface

// File: rtl/measurement_byte_serializer.sv
// Measurement byte serializer: collects GRID_WIDTH_U rounds of syndrome
// measurements and emits them as an 8-bit stream framed by a header byte
// and a start byte, one decode block per header/start pair.
// Optional statistics ports are enabled by defining SERIALIZER_STATS_EN.
module measurement_byte_serializer #(
    parameter int         GRID_WIDTH_X = 4,
    parameter int         GRID_WIDTH_Z = 1,
    parameter int         GRID_WIDTH_U = 3,
    parameter logic [7:0] HEADER_BYTE  = 8'h01,
    parameter logic [7:0] START_BYTE   = 8'h02
) (
    input  logic clk,
    input  logic reset,
    measurement_byte_serializer_if.slave bus
`ifdef SERIALIZER_STATS_EN
    ,
    output logic [15:0] blocks_sent,
    output logic [15:0] stall_cycles
`endif
);

    localparam int PU_COUNT_PER_ROUND = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int BYTES_PER_ROUND    = (PU_COUNT_PER_ROUND + 7) / 8;
    localparam int SHIFT_W            = BYTES_PER_ROUND * 8;
    localparam int ROUND_CNT_W        = $clog2(GRID_WIDTH_U + 1);
    localparam int BYTE_CNT_W         = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;

    localparam logic [ROUND_CNT_W-1:0] LAST_ROUND = ROUND_CNT_W'(GRID_WIDTH_U - 1);
    localparam logic [BYTE_CNT_W-1:0]  LAST_BYTE  = BYTE_CNT_W'(BYTES_PER_ROUND - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        SEND,
        START
    } state_t;

    state_t                 state_reg;
    logic                   round_ready_reg;
    logic [7:0]             out_data_reg;
    logic                   out_valid_reg;
    logic                   block_done_reg;
    logic [ROUND_CNT_W-1:0] round_cnt_reg;
    logic [BYTE_CNT_W-1:0]  byte_cnt_reg;
    logic [SHIFT_W-1:0]     shift_reg;

    logic [SHIFT_W-1:0]     captured;
    logic [SHIFT_W-1:0]     shifted;
    logic                   out_fire;
    logic                   round_fire;

    // Round word padded up to a whole number of bytes; pad bits are zero.
    for (genvar gi = 0; gi < SHIFT_W; gi++) begin : g_capture
        if (gi < PU_COUNT_PER_ROUND) begin : g_bit
            assign captured[gi] = bus.round_measurements[gi];
        end else begin : g_pad
            assign captured[gi] = 1'b0;
        end
    end

    // Bytes leave LSB-first, so the next byte is always the low 8 bits
    // after a right shift.
    assign shifted    = shift_reg >> 8;
    assign out_fire   = out_valid_reg & bus.out_ready;
    assign round_fire = bus.round_valid & round_ready_reg;

    // Framing FSM; every output is a register so the core sees clean timing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            round_ready_reg <= 1'b0;
            out_data_reg    <= 8'h00;
            out_valid_reg   <= 1'b0;
            block_done_reg  <= 1'b0;
            round_cnt_reg   <= '0;
            byte_cnt_reg    <= '0;
            shift_reg       <= '0;
        end else begin
            block_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    round_ready_reg <= 1'b0;
                    if (bus.round_valid) begin
                        out_data_reg  <= HEADER_BYTE;
                        out_valid_reg <= 1'b1;
                        state_reg     <= HEADER;
                    end
                end
                HEADER: begin
                    if (out_fire) begin
                        out_valid_reg   <= 1'b0;
                        round_ready_reg <= 1'b1;
                        state_reg       <= LOAD;
                    end
                end
                LOAD: begin
                    // Waits here indefinitely for the next round.
                    if (round_fire) begin
                        shift_reg       <= captured;
                        out_data_reg    <= captured[7:0];
                        out_valid_reg   <= 1'b1;
                        round_ready_reg <= 1'b0;
                        byte_cnt_reg    <= '0;
                        state_reg       <= SEND;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (byte_cnt_reg == LAST_BYTE) begin
                            if (round_cnt_reg == LAST_ROUND) begin
                                // Valid stays high: the start byte follows directly.
                                out_data_reg <= START_BYTE;
                                state_reg    <= START;
                            end else begin
                                round_cnt_reg   <= round_cnt_reg + 1'b1;
                                out_valid_reg   <= 1'b0;
                                round_ready_reg <= 1'b1;
                                state_reg       <= LOAD;
                            end
                        end else begin
                            shift_reg    <= shifted;
                            out_data_reg <= shifted[7:0];
                            byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        end
                    end
                end
                START: begin
                    if (out_fire) begin
                        out_valid_reg  <= 1'b0;
                        block_done_reg <= 1'b1;
                        round_cnt_reg  <= '0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg   <= 1'b0;
                    round_ready_reg <= 1'b0;
                    state_reg       <= IDLE;
                end
            endcase
        end
    end

    assign bus.round_ready = round_ready_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.block_done  = block_done_reg;

`ifdef SERIALIZER_STATS_EN
    logic [15:0] blocks_sent_reg;
    logic [15:0] stall_cycles_reg;

    // Block counter wraps; stall counter saturates so it never reads low after a long stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blocks_sent_reg  <= 16'h0000;
            stall_cycles_reg <= 16'h0000;
        end else begin
            if (block_done_reg) begin
                blocks_sent_reg <= blocks_sent_reg + 16'd1;
            end
            if (out_valid_reg && !bus.out_ready && (stall_cycles_reg != 16'hFFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 16'd1;
            end
        end
    end

    assign blocks_sent  = blocks_sent_reg;
    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_measurement_byte_serializer.sv
// Bench for measurement_byte_serializer: a default instance (4x1 PUs, 3 rounds)
// and a 5x2 PU, 2-round instance. Expected byte streams come from a frame
// model (header, padded round bytes LSB-first, start) checked every cycle.
module tb_measurement_byte_serializer;

    localparam logic [7:0] HDR = 8'h01;
    localparam logic [7:0] STB = 8'h02;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    measurement_byte_serializer_if #(.PU_COUNT(4))  bus_a ();
    measurement_byte_serializer_if #(.PU_COUNT(10)) bus_b ();

    logic [9:0] meas [2];
    logic       rv   [2];
    logic       ordy [2];

    assign bus_a.round_measurements = meas[0][3:0];
    assign bus_a.round_valid        = rv[0];
    assign bus_a.out_ready          = ordy[0];
    assign bus_b.round_measurements = meas[1];
    assign bus_b.round_valid        = rv[1];
    assign bus_b.out_ready          = ordy[1];

    logic [7:0] o_data  [2];
    logic       o_valid [2];
    logic       o_rr    [2];
    logic       o_done  [2];

    assign o_data[0]  = bus_a.out_data;
    assign o_valid[0] = bus_a.out_valid;
    assign o_rr[0]    = bus_a.round_ready;
    assign o_done[0]  = bus_a.block_done;
    assign o_data[1]  = bus_b.out_data;
    assign o_valid[1] = bus_b.out_valid;
    assign o_rr[1]    = bus_b.round_ready;
    assign o_done[1]  = bus_b.block_done;

`ifdef SERIALIZER_STATS_EN
    logic [15:0] bs_a, sc_a, bs_b, sc_b;
`endif

    measurement_byte_serializer dut_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_a)
`ifdef SERIALIZER_STATS_EN
        ,
        .blocks_sent  (bs_a),
        .stall_cycles (sc_a)
`endif
    );

    measurement_byte_serializer #(
        .GRID_WIDTH_X (5),
        .GRID_WIDTH_Z (2),
        .GRID_WIDTH_U (2)
    ) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_b)
`ifdef SERIALIZER_STATS_EN
        ,
        .blocks_sent  (bs_b),
        .stall_cycles (sc_b)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state: bytes per round for each instance, expected frame queue
    // (bit 8 marks the start byte), observed bytes with cycle stamps.
    int         bpr [2] = '{1, 2};
    logic [8:0] exp_q   [2][$];
    logic [7:0] obs_q   [2][$];
    int         obs_cyc [2][$];
    int         done_cnt   [2];
    int         stall_seen [2];
    int         cyc = 0;

    logic [9:0] rnd [4];
    logic [7:0] lit [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Per-cycle compare against the frame model.
    initial begin : compare
        logic       stall_prev [2];
        logic [7:0] data_prev  [2];
        logic       done_exp   [2];
        logic [8:0] e;
        for (int d = 0; d < 2; d++) begin
            stall_prev[d] = 1'b0;
            data_prev[d]  = 8'h00;
            done_exp[d]   = 1'b0;
            done_cnt[d]   = 0;
            stall_seen[d] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    stall_prev[d] = 1'b0;
                    done_exp[d]   = 1'b0;
                    stall_seen[d] = 0;
                end else begin
                    check($sformatf("dut%0d block_done", d), 32'(o_done[d]), 32'(done_exp[d]));
                    if (o_done[d]) done_cnt[d]++;
                    done_exp[d] = 1'b0;
                    if (stall_prev[d]) begin
                        check($sformatf("dut%0d held valid", d), 32'(o_valid[d]), 32'd1);
                        check($sformatf("dut%0d held data", d), 32'(o_data[d]), 32'(data_prev[d]));
                    end
                    if (o_valid[d]) begin
                        check($sformatf("dut%0d round_ready while out_valid", d), 32'(o_rr[d]), 32'd0);
                    end
                    if (o_valid[d] && ordy[d]) begin
                        $display("dut%0d byte %02h cycle %0d", d, o_data[d], cyc);
                        if (exp_q[d].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL dut%0d unexpected byte: got %02h, required none", d, o_data[d]);
                        end else begin
                            e = exp_q[d].pop_front();
                            check($sformatf("dut%0d byte", d), 32'(o_data[d]), 32'(e[7:0]));
                            done_exp[d] = e[8];
                        end
                        obs_q[d].push_back(o_data[d]);
                        obs_cyc[d].push_back(cyc);
                    end
                    if (o_valid[d] && !ordy[d]) stall_seen[d]++;
                    stall_prev[d] = o_valid[d] && !ordy[d];
                    data_prev[d]  = o_data[d];
                end
            end
        end
    end

    task automatic drive_round(input int d, input logic [9:0] val, input bit hold);
        int  n   = 0;
        bit  got = 0;
        meas[d] = val;
        rv[d]   = 1'b1;
        while (!got && n < 300) begin
            @(negedge clk);
            if (o_rr[d] && rv[d]) got = 1;
            n++;
        end
        if (!got) fail_now($sformatf("dut%0d round accept", d));
        @(posedge clk);
        #1;
        if (!hold) rv[d] = 1'b0;
    endtask

    // Queue the whole expected frame, then hand the rounds over.
    task automatic drive_block(input int d, input int n, input bit hold_last, input int gap);
        logic [9:0] tmp;
        logic [9:0] r [4];
        r = rnd;
        exp_q[d].push_back({1'b0, HDR});
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < bpr[d]; k++) begin
                tmp = r[i] >> (8 * k);
                exp_q[d].push_back({1'b0, tmp[7:0]});
            end
        end
        exp_q[d].push_back({1'b1, STB});
        for (int i = 0; i < n; i++) begin
            drive_round(d, r[i], (i == n - 1) ? hold_last : 1'b0);
            if (gap > 0 && i < n - 1) begin
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic stall_on(input int d, input logic [7:0] b, input int n);
        int k    = 0;
        bit seen = 0;
        while (!seen && k < 300) begin
            @(posedge clk);
            #1;
            if (o_valid[d] && o_data[d] == b) seen = 1;
            k++;
        end
        if (!seen) fail_now($sformatf("dut%0d stall target", d));
        ordy[d] = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check($sformatf("dut%0d stall data", d), 32'(o_data[d]), 32'(b));
            check($sformatf("dut%0d stall valid", d), 32'(o_valid[d]), 32'd1);
            check($sformatf("dut%0d stall round_ready", d), 32'(o_rr[d]), 32'd0);
            @(posedge clk);
            #1;
        end
        ordy[d] = 1'b1;
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        while (exp_q[d].size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[d].size() != 0) begin
            fail_now($sformatf("dut%0d drain", d));
            exp_q[d].delete();
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_lit(input int d, input int n, input string name);
        check({name, " count"}, 32'(obs_q[d].size()), 32'(n));
        for (int i = 0; i < n && i < obs_q[d].size(); i++) begin
            check($sformatf("%s byte%0d", name, i), 32'(obs_q[d][i]), 32'(lit[i]));
        end
    endtask

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            obs_q[d].delete();
            obs_cyc[d].delete();
            done_cnt[d] = 0;
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            check($sformatf("dut%0d reset out_valid", d), 32'(o_valid[d]), 32'd0);
            check($sformatf("dut%0d reset out_data", d), 32'(o_data[d]), 32'd0);
            check($sformatf("dut%0d reset round_ready", d), 32'(o_rr[d]), 32'd0);
            check($sformatf("dut%0d reset block_done", d), 32'(o_done[d]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            meas[d] = '0;
            rv[d]   = 1'b0;
            ordy[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        pulse_reset();
`ifdef SERIALIZER_STATS_EN
        check("reset blocks_sent", 32'(bs_a), 32'd0);
        check("reset stall_cycles", 32'(sc_a), 32'd0);
`endif

        // 1: three rounds at full rate, with idle gaps between rounds.
        clear_obs();
        rnd = '{10'hA, 10'h1, 10'hF, 10'h0};
        drive_block(0, 3, 1'b0, 2);
        wait_drain(0);
        lit = '{8'h01, 8'h0A, 8'h01, 8'h0F, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_lit(0, 5, "t1");
        check("t1 block_done pulses", 32'(done_cnt[0]), 32'd1);

        // 2: consumer stalls 5 cycles on byte 0A.
        clear_obs();
        fork
            drive_block(0, 3, 1'b0, 0);
            stall_on(0, 8'h0A, 5);
        join
        wait_drain(0);
        check_lit(0, 5, "t2");

        // 3: 10-bit rounds, two rounds per block.
        clear_obs();
        rnd = '{10'h2B5, 10'h001, 10'h0, 10'h0};
        drive_block(1, 2, 1'b0, 0);
        wait_drain(1);
        lit = '{8'h01, 8'hB5, 8'h02, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
        check_lit(1, 6, "t3");

        // 4: reset while a round byte is pending, then a fresh block.
        clear_obs();
        exp_q[0].push_back({1'b0, HDR});
        exp_q[0].push_back({1'b0, 8'h06});
        drive_round(0, 10'h6, 1'b0);
        ordy[0] = 1'b0;
        @(negedge clk);
        check("t4 mid-send data", 32'(o_data[0]), 32'h06);
        check("t4 mid-send valid", 32'(o_valid[0]), 32'd1);
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        pulse_reset();
        clear_obs();
        rnd = '{10'h8, 10'h4, 10'hE, 10'h0};
        drive_block(0, 3, 1'b0, 0);
        wait_drain(0);
        lit = '{8'h01, 8'h08, 8'h04, 8'h0E, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check_lit(0, 5, "t4");

        // 5: back-to-back blocks with round_valid held high.
        clear_obs();
        rnd = '{10'h3, 10'h5, 10'h9, 10'h0};
        drive_block(0, 3, 1'b1, 0);
        rnd = '{10'hC, 10'h7, 10'h0, 10'h0};
        drive_block(0, 3, 1'b0, 0);
        wait_drain(0);
        lit = '{8'h01, 8'h03, 8'h05, 8'h09, 8'h02, 8'h01, 8'h0C, 8'h07, 8'h00, 8'h02};
        check_lit(0, 10, "t5");
        if (obs_cyc[0].size() >= 6) begin
            check("t5 start-to-header cycles", 32'(obs_cyc[0][5] - obs_cyc[0][4]), 32'd2);
        end else begin
            fail_now("t5 byte stamps");
        end
        check("t5 block_done pulses", 32'(done_cnt[0]), 32'd2);

`ifdef SERIALIZER_STATS_EN
        // 6: statistics counters.
        pulse_reset();
        rnd = '{10'hA, 10'h1, 10'hF, 10'h0};
        drive_block(0, 3, 1'b0, 0);
        wait_drain(0);
        fork
            drive_block(0, 3, 1'b0, 0);
            stall_on(0, 8'h0A, 4);
        join
        wait_drain(0);
        fork
            drive_block(0, 3, 1'b0, 0);
            stall_on(0, 8'h0F, 3);
        join
        wait_drain(0);
        check("t6 blocks_sent", 32'(bs_a), 32'd3);
        check("t6 stall_cycles", 32'(sc_a), 32'd7);
        check("t6 stall_cycles vs model", 32'(sc_a), 32'(stall_seen[0]));
        force dut_a.stall_cycles_reg = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut_a.stall_cycles_reg;
        fork
            drive_block(0, 3, 1'b0, 0);
            stall_on(0, 8'h0A, 4);
        join
        wait_drain(0);
        check("t6 stall_cycles saturated", 32'(sc_a), 32'hFFFF);
        check("t6 blocks_sent after 4", 32'(bs_a), 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
